// File: rtl/resolution_text_sequencer.sv
// ============================================================================
// resolution_text_sequencer : fetches resolution-label ROM rows and serialises
//                             them into a scaled on-screen pixel stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

package resolution_text_pkg;
    typedef logic [2:0] VideoMode;
endpackage

module resolution_text_sequencer
    import resolution_text_pkg::*;
#(
    parameter int LINE_BITS  = 136,
    parameter int ROWS       = 16,
    parameter int SCALE_LOG2 = 1,
    parameter int X_POS      = 16,
    parameter int Y_POS      = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic [11:0]             x,
    input  logic [11:0]             y,
    input  logic                    de,
    input  VideoMode                videoMode_in,
    output VideoMode                rom_videoMode,
    output logic [$clog2(ROWS)-1:0] rom_addr,
    input  logic [LINE_BITS-1:0]    rom_q,
    output logic                    pixel_on,
    output logic                    busy,
    output logic                    miss
);

    localparam int c_ROW_W = $clog2(ROWS);
    localparam int c_PIX_W = $clog2(LINE_BITS);
    localparam int c_REP_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [12:0]        c_Y_LO     = 13'(Y_POS);
    localparam logic [12:0]        c_Y_HI     = 13'(Y_POS + (ROWS << SCALE_LOG2));
    localparam logic [11:0]        c_X_POS    = 12'(X_POS);
    localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(LINE_BITS - 1);
    localparam logic [c_REP_W-1:0] c_REP_MAX  = c_REP_W'((1 << SCALE_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_READY   = 3'd3,
        S_SHIFT   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [LINE_BITS-1:0]   r_shift;
    logic [c_PIX_W-1:0]     r_pix_cnt;
    logic [c_REP_W-1:0]     r_rep_cnt;
    logic                   r_missed;

    logic [12:0]            w_y_ext;
    logic [12:0]            w_dy;
    logic                   w_in_rows;
    logic [c_ROW_W-1:0]     w_row;
    logic                   w_at_start;
    logic                   w_emit;
    logic                   w_rep_wrap;
    logic                   w_last;

    always_comb begin
        w_y_ext    = {1'b0, y};
        w_dy       = w_y_ext - c_Y_LO;
        w_in_rows  = (w_y_ext >= c_Y_LO) && (w_y_ext < c_Y_HI);
        w_row      = c_ROW_W'(w_dy >> SCALE_LOG2);
        w_at_start = de && (x == c_X_POS);
        w_emit     = de && ((r_state == S_SHIFT) ||
                            ((r_state == S_READY) && (x == c_X_POS)));
        w_rep_wrap = (r_rep_cnt == c_REP_MAX);
        w_last     = w_rep_wrap && (r_pix_cnt == c_PIX_LAST);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_pix_cnt     <= '0;
            r_rep_cnt     <= '0;
            r_missed      <= 1'b0;
            rom_addr      <= '0;
            rom_videoMode <= '0;
            pixel_on      <= 1'b0;
            busy          <= 1'b0;
            miss          <= 1'b0;
        end else begin
            pixel_on <= 1'b0;
            miss     <= 1'b0;

            if (frame_start) begin
                rom_videoMode <= videoMode_in;
            end

            // A new line always wins over whatever the previous line was doing
            if (line_start) begin
                r_missed <= 1'b0;
                if (w_in_rows) begin
                    rom_addr <= w_row;
                    r_state  <= S_FETCH;
                    busy     <= 1'b1;
                end else begin
                    r_state  <= S_IDLE;
                    busy     <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (w_at_start) begin
                            miss     <= 1'b1;
                            r_missed <= 1'b1;
                        end
                        r_state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        r_shift   <= rom_q;
                        r_pix_cnt <= '0;
                        r_rep_cnt <= '0;
                        if (r_missed || w_at_start) begin
                            miss    <= w_at_start && !r_missed;
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= S_READY;
                        end
                    end
                    S_READY, S_SHIFT: begin
                        if (w_emit) begin
                            pixel_on <= r_shift[LINE_BITS-1];
                            r_state  <= S_SHIFT;
                            if (w_rep_wrap) begin
                                r_rep_cnt <= '0;
                                r_shift   <= r_shift << 1;
                                r_pix_cnt <= r_pix_cnt + 1'b1;
                                if (w_last) begin
                                    r_state <= S_IDLE;
                                    busy    <= 1'b0;
                                end
                            end else begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_resolution_text_sequencer.sv
// ============================================================================
// tb_resolution_text_sequencer : directed self-checking bench.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_resolution_text_sequencer;
    import resolution_text_pkg::*;

    logic           clock;
    logic           reset_n;
    logic           frame_start;
    logic           line_start;
    logic [11:0]    x;
    logic [11:0]    y;
    logic           de;
    VideoMode       videoMode_in;
    VideoMode       rom_videoMode;
    logic [3:0]     rom_addr;
    logic [135:0]   rom_q;
    logic           pixel_on;
    logic           busy;
    logic           miss;

    int n_tests = 0;
    int n_fail  = 0;

    resolution_text_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .x             (x),
        .y             (y),
        .de            (de),
        .videoMode_in  (videoMode_in),
        .rom_videoMode (rom_videoMode),
        .rom_addr      (rom_addr),
        .rom_q         (rom_q),
        .pixel_on      (pixel_on),
        .busy          (busy),
        .miss          (miss)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [271:0] obs, input logic [271:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse line_start for one cycle, then advance to READY (T+3)
    task automatic start_line(input logic [11:0] yy);
        line_start = 1'b1;
        y          = yy;
        de         = 1'b0;
        step();
        line_start = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [271:0] got;
        logic [271:0] exp_v;
        logic [135:0] pat;
        int           cnt;
        int           gap;
        int           acc;
        int           acc2;
        int           ys [6]        = '{15, 16, 17, 18, 47, 48};
        int           exp_busy [6]  = '{0, 1, 1, 1, 1, 0};
        int           exp_addr [6]  = '{0, 0, 0, 1, 15, 15};

        reset_n      = 1'b0;
        frame_start  = 1'b0;
        line_start   = 1'b0;
        x            = '0;
        y            = '0;
        de           = 1'b0;
        videoMode_in = 3'd0;
        rom_q        = '0;
        step();
        step();
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pix", 32'(pixel_on), 0);
        chk("rst_miss", 32'(miss), 0);
        chk("rst_mode", 32'(rom_videoMode), 0);
        reset_n = 1'b1;

        // Mode latch only on frame_start
        videoMode_in = 3'd5;
        step();
        chk("mode_no_fs", 32'(rom_videoMode), 0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("mode_fs", 32'(rom_videoMode), 5);
        videoMode_in = 3'd2;
        step();
        step();
        chk("mode_midframe", 32'(rom_videoMode), 5);
        frame_start  = 1'b1;
        line_start   = 1'b1;
        videoMode_in = 3'd6;
        y            = 12'd16;
        step();
        frame_start = 1'b0;
        line_start  = 1'b0;
        chk("mode_coinc", 32'(rom_videoMode), 6);
        chk("coinc_busy", 32'(busy), 1);
        chk("coinc_addr", 32'(rom_addr), 0);
        step();

        // Row mapping across the label's vertical boundaries
        for (int i = 0; i < 6; i++) begin
            line_start = 1'b1;
            y          = 12'(ys[i]);
            step();
            line_start = 1'b0;
            chk($sformatf("row_busy_y%0d", ys[i]), 32'(busy), 32'(exp_busy[i]));
            chk($sformatf("row_addr_y%0d", ys[i]), 32'(rom_addr), 32'(exp_addr[i]));
            step();
        end

        // Serialisation of a single set MSB
        rom_q = {1'b1, 135'b0};
        start_line(12'd16);
        got = '0;
        for (int i = 0; i < 272; i++) begin
            de = 1'b1;
            x  = 12'(16 + i);
            step();
            got[271 - i] = pixel_on;
            if (i == 270) chk("ser_busy_hold", 32'(busy), 1);
        end
        chk_vec("ser_pattern", got, {2'b11, 270'b0});
        chk("ser_busy_end", 32'(busy), 0);
        de = 1'b1;
        x  = 12'd288;
        step();
        chk("ser_after", 32'(pixel_on), 0);

        // de gap after ten pixels
        pat   = {8'hA5, 120'h0, 8'h3C};
        rom_q = pat;
        for (int k = 0; k < 272; k++) exp_v[271 - k] = pat[135 - k / 2];
        start_line(12'd30);
        got = '0;
        cnt = 0;
        gap = 0;
        acc = 0;
        for (int c = 0; c < 300 && cnt < 272; c++) begin
            if (cnt == 10 && gap < 5) begin
                de = 1'b0;
                gap++;
            end else begin
                de = 1'b1;
            end
            x = 12'(16 + c);
            step();
            if (de) begin
                got[271 - cnt] = pixel_on;
                cnt++;
            end else begin
                acc += int'(pixel_on);
            end
        end
        chk("gap_count", 32'(cnt), 272);
        chk("gap_zero", 32'(acc), 0);
        chk_vec("gap_pattern", got, exp_v);
        chk("gap_busy_end", 32'(busy), 0);
        de = 1'b1;
        x  = 12'd16;
        step();
        chk("gap_overrun", 32'(pixel_on), 0);

        // Label start reached during CAPTURE
        rom_q      = '1;
        de         = 1'b0;
        line_start = 1'b1;
        y          = 12'd20;
        step();
        line_start = 1'b0;
        chk("miss_addr", 32'(rom_addr), 2);
        step();
        chk("miss_pre", 32'(miss), 0);
        de = 1'b1;
        x  = 12'd16;
        step();
        chk("miss_pulse", 32'(miss), 1);
        chk("miss_busy", 32'(busy), 0);
        acc  = 0;
        acc2 = 0;
        for (int i = 0; i < 300; i++) begin
            x = 12'((17 + i) % 290);
            step();
            acc  += int'(pixel_on);
            acc2 += int'(miss);
        end
        chk("miss_no_pixels", 32'(acc), 0);
        chk("miss_one_cycle", 32'(acc2), 0);

        // Reset asserted in the middle of SHIFT
        start_line(12'd40);
        chk("rms_addr", 32'(rom_addr), 12);
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            de = 1'b1;
            x  = 12'(16 + i);
            step();
            acc += int'(pixel_on);
        end
        chk("rms_ones", 32'(acc), 50);
        reset_n = 1'b0;
        x       = 12'd66;
        step();
        reset_n = 1'b1;
        chk("rms_pix", 32'(pixel_on), 0);
        chk("rms_busy", 32'(busy), 0);
        chk("rms_addr0", 32'(rom_addr), 0);
        chk("rms_mode0", 32'(rom_videoMode), 0);
        x = 12'd67;
        step();
        chk("rms_idle_pix", 32'(pixel_on), 0);
        line_start = 1'b1;
        y          = 12'd18;
        de         = 1'b0;
        step();
        line_start = 1'b0;
        chk("rms_resume_busy", 32'(busy), 1);
        chk("rms_resume_addr", 32'(rom_addr), 1);
        step();
        step();
        de = 1'b1;
        x  = 12'd16;
        step();
        chk("rms_resume_pix", 32'(pixel_on), 1);
        de = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/resolution_text_sequencer.md
# resolution_text_sequencer

Sequencer that drives the resolution-label character ROM and turns its 136-bit row words into an on-screen pixel stream. On each visible line it works out which ROM row the line needs and issues the address. It then captures the registered ROM word and shifts it out MSB-first at integer scale once the raster reaches the label's X origin. It sits between the video timing generator and the overlay mixer, and it is the only master of the ROM's `addr` and `videoMode` inputs.

## Interface
Parameters:
- `LINE_BITS`, 136, width of one ROM row word (`RESLINE_SIZE`).
- `ROWS`, 16, number of ROM rows (4-bit address).
- `SCALE_LOG2`, 1, log2 of the pixel replication factor; scale = 2^SCALE_LOG2, applied horizontally and vertically.
- `X_POS`, 16, first active pixel column of the label.
- `Y_POS`, 16, first active line of the label.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse at the start of each frame.
- `line_start`  in  1  one-cycle pulse at the start of each line, before active video.
- `x`  in  12  current pixel column, valid while `de`=1.
- `y`  in  12  current line number, valid at `line_start`.
- `de`  in  1  active-video pixel enable.
- `videoMode_in`  in  VideoMode  requested video mode.
- `rom_videoMode`  out  VideoMode  frame-stable mode driven to the ROM.
- `rom_addr`  out  4  ROM row address.
- `rom_q`  in  LINE_BITS  ROM data, one clock after `rom_addr`.
- `pixel_on`  out  1  label foreground pixel.
- `busy`  out  1  high in every state except IDLE.
- `miss`  out  1  one-cycle pulse when the label start was reached before row data was ready.

## Operation
- **Mode latch.** `rom_videoMode` loads `videoMode_in` only on `frame_start`. The mode never changes mid-frame.
- **Row select.** On `line_start`, if Y_POS ≤ y < Y_POS + ROWS·2^SCALE_LOG2:
  - row = (y − Y_POS) >> SCALE_LOG2;
  - `rom_addr` ← row;
  - state → FETCH.
  - Otherwise → IDLE with `pixel_on`=0.
- **States:**
  - IDLE: waits for `line_start`.
  - FETCH: one cycle, covering the ROM's register stage.
  - CAPTURE: `shift_reg` ← `rom_q`, with bit LINE_BITS−1 first; pixel counter ← 0; replicate counter ← 0; → READY.
  - READY: waits for `de`=1 and x=X_POS, then → SHIFT. That first pixel is emitted in the same transition.
  - SHIFT: on each `de`=1 cycle, emit the current MSB and increment the replicate counter. When it wraps at 2^SCALE_LOG2 − 1, shift `shift_reg` left by one and increment the pixel counter.
    - After LINE_BITS·2^SCALE_LOG2 emitted pixels → IDLE.
    - `de`=0 holds all counters and emits 0.
- **Missed start.** If `de`=1 and x=X_POS while the state is FETCH or CAPTURE:
  - `miss` pulses;
  - that line emits nothing;
  - the state goes to IDLE after CAPTURE.
- **Restart.** `line_start` in any non-IDLE state aborts the current line and re-evaluates the row, so `line_start` always has priority.
- **Simultaneous pulses.** `frame_start` and `line_start` in the same cycle: the mode latch and row select both take effect.
- **Reset.** `reset_n`=0 takes priority over everything, including mid-line. It forces IDLE, `rom_addr`=0, `rom_videoMode`=0, `shift_reg`=0, `pixel_on`=0, `busy`=0, `miss`=0.

## Timing
- `line_start` at cycle T → `rom_addr` valid at T+1 (FETCH) → `rom_q` captured at T+2 (CAPTURE) → READY from T+3.
- The timing generator must present x=X_POS no earlier than T+3; otherwise the line is missed.
- `pixel_on` is registered: it reflects the (x, de) sample of the previous cycle, a fixed 1-cycle latency. The mixer aligns for this.
- `pixel_on`=0 whenever the state is not SHIFT, or `de` was 0.
- `busy` is registered and goes high at T+1.
- The label spans LINE_BITS·2^SCALE_LOG2 = 272 columns and ROWS·2^SCALE_LOG2 = 32 lines at the default parameters.
- No combinational path from inputs to outputs.

## Test plan
- **Reset mid-SHIFT.** Assert `reset_n`=0 for 1 cycle at pixel 50 → next cycle `pixel_on`=0, `busy`=0, `rom_addr`=0. Subsequent `line_start` events resume normal operation.
- **Row mapping.** Defaults; `line_start` with y=15, 16, 17, 18, 47, 48:
  - y=15 → IDLE;
  - y=16 and y=17 → `rom_addr` 0;
  - y=18 → `rom_addr` 1;
  - y=47 → `rom_addr` 15;
  - y=48 → IDLE.
- **Serialization.** `rom_q` = 1 followed by 135 zeros, `de` always 1, x counting:
  - `pixel_on`=1 exactly for x=16 and x=17, seen one cycle later;
  - zero for the remaining 270 pixels;
  - `busy` drops after pixel 271.
- **`de` gap.** `de`=0 for 5 cycles at pixel 10 → the output resumes with the identical pattern and the total emitted count is still 272.
- **Missed start.** x=X_POS with `de`=1 at T+2 → `miss`=1 for one cycle; `pixel_on` stays 0 for the whole line.
- **Mode stability.** Change `videoMode_in` mid-frame → `rom_videoMode` is unchanged until the next `frame_start`, updates the cycle after it, and also updates when `frame_start` and `line_start` coincide.
